// File: rtl/ex_div_ctrl.sv
// EX-stage sequencer for the iterative divider: issues div_op, stalls the pipe
// while the divider runs, commits remainder/quotient to HI/LO and owns MTHI/MTLO.
module ex_div_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic        flush,
    input  logic        hi_we,
    input  logic [31:0] hi_wdata,
    input  logic        lo_we,
    input  logic [31:0] lo_wdata,
    output logic [1:0]  div_op,
    output logic [31:0] dividend,
    output logic [31:0] divisor,
    input  logic [63:0] div_result,
    input  logic        div_done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        timeout_err
);

    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [WDW-1:0] wdog_r;
    logic [31:0]    hi_r;
    logic [31:0]    lo_r;
    logic           timeout_err_r;
    logic           issue_s;
    logic           commit_s;
    logic           expire_s;
    logic           stall_s;
    logic [1:0]     div_op_s;

    assign dividend    = req_rs;
    assign divisor     = req_rt;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign timeout_err = timeout_err_r;
    assign stall       = stall_s;
    assign div_op      = div_op_s;

    // Decode the three events that move the sequencer: issue, commit, watchdog expiry
    always_comb begin
        issue_s  = 1'b0;
        commit_s = 1'b0;
        expire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && !flush && div_done) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            BUSY: begin
                if (flush) begin
                    commit_s = 1'b0;
                end else if (div_done) begin
                    commit_s = 1'b1;
                end else if (wdog_r == WDOG_LAST) begin
                    expire_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a flush in BUSY abandons the op, the divider drains on its own
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (flush || commit_s || expire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output logic: stall is released in the commit cycle so the instruction leaves EX
    always_comb begin
        stall_s  = 1'b0;
        div_op_s = 2'b00;
        if (rst) begin
            stall_s  = 1'b0;
            div_op_s = 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && !flush) begin
                        stall_s = 1'b1;
                        if (issue_s) begin
                            div_op_s = req_signed ? 2'b10 : 2'b01;
                        end else begin
                            div_op_s = 2'b00;
                        end
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                BUSY: begin
                    stall_s = !(flush || commit_s || expire_s);
                end
                default: begin
                    stall_s  = 1'b0;
                    div_op_s = 2'b00;
                end
            endcase
        end
    end

    // Watchdog counts BUSY cycles, cleared at issue
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_r <= {WDW{1'b0}};
        end else if (issue_s) begin
            wdog_r <= {WDW{1'b0}};
        end else if (state_r == BUSY) begin
            wdog_r <= wdog_r + WDW'(1);
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // HI/LO: a divider commit takes priority over an MTHI/MTLO in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s) begin
            hi_r <= div_result[63:32];
            lo_r <= div_result[31:0];
        end else begin
            if (hi_we) begin
                hi_r <= hi_wdata;
            end else begin
                hi_r <= hi_r;
            end
            if (lo_we) begin
                lo_r <= lo_wdata;
            end else begin
                lo_r <= lo_r;
            end
        end
    end

    // Sticky watchdog error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
        end else if (expire_s) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

endmodule
